// File: rtl/eth_cmd_decoder.sv
// Host command frame decoder: parses 8-byte UDP payload frames into start/sample-count commands.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for first header byte 0x55
// HDR2    | expecting second header byte 0xA5
// CMD     | latching command byte, seeding checksum
// ARG     | shifting in 4 big-endian argument bytes
// CSUM    | comparing received checksum byte
// EXEC    | one cycle: validate and execute the command
// DISCARD | dropping bytes until rx_frame_end
module eth_cmd_decoder #(
    parameter logic [31:0] DEFAULT_SAMPLE_NUM = 32'd1024,
    parameter logic [31:0] MAX_SAMPLE_NUM     = 32'd67108864,
    parameter logic [23:0] TIMEOUT_CYCLES     = 24'd125000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_data_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_frame_end,
    input  logic        sample_busy,
    output logic        start_sample,
    output logic [31:0] set_sample_num,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR2, S_CMD, S_ARG, S_CSUM, S_EXEC, S_DISCARD
    } state_t;

    localparam logic [1:0] ERR_CSUM = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CMD  = 2'd2;
    localparam logic [1:0] ERR_BUSY = 2'd3;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pend_err_q, pend_err_d;
    logic [1:0]  pend_code_q, pend_code_d;
    logic        start_q, start_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] num_q, num_d;
    logic        arg_ok;
    state_t      idle_next;

`ifdef CMD_TIMEOUT_EN
    logic [23:0] tmo_q, tmo_d;
`else
    logic        timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

    assign arg_ok = (arg_q != 32'd0) && (arg_q <= MAX_SAMPLE_NUM);

    // EXEC shares the IDLE byte decision so a frame may follow immediately.
    always_comb begin
        idle_next = S_IDLE;
        if (rx_data_valid && !rx_frame_end) begin
            idle_next = (rx_data == 8'h55) ? S_HDR2 : S_DISCARD;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        csum_d      = csum_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        pend_err_d  = 1'b0;
        pend_code_d = pend_code_q;
        start_d     = 1'b0;
        ok_d        = 1'b0;
        err_d       = pend_err_q;
        code_d      = pend_err_q ? pend_code_q : code_q;
`ifdef CMD_TIMEOUT_EN
        tmo_d       = 24'd0;
`endif

        case (state_q)
            S_IDLE: state_d = idle_next;
            S_HDR2: begin
                if (rx_data_valid) begin
                    if (rx_data == 8'hA5) begin
                        if (rx_frame_end) begin
                            state_d     = S_IDLE;
                            pend_err_d  = 1'b1;
                            pend_code_d = ERR_LEN;
                        end else begin
                            state_d = S_CMD;
                        end
                    end else begin
                        state_d = rx_frame_end ? S_IDLE : S_DISCARD;
                    end
                end
            end
            S_CMD: begin
                if (rx_data_valid) begin
                    cmd_d  = rx_data;
                    csum_d = rx_data;
                    cnt_d  = 2'd0;
                    if (rx_frame_end) begin
                        state_d     = S_IDLE;
                        pend_err_d  = 1'b1;
                        pend_code_d = ERR_LEN;
                    end else begin
                        state_d = S_ARG;
                    end
                end
            end
            S_ARG: begin
                if (rx_data_valid) begin
                    arg_d  = {arg_q[23:0], rx_data};
                    csum_d = csum_q + rx_data;
                    cnt_d  = cnt_q + 2'd1;
                    if (rx_frame_end) begin
                        state_d     = S_IDLE;
                        pend_err_d  = 1'b1;
                        pend_code_d = ERR_LEN;
                    end else if (cnt_q == 2'd3) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_data_valid) begin
                    if (rx_data != csum_q) begin
                        state_d     = rx_frame_end ? S_IDLE : S_DISCARD;
                        pend_err_d  = 1'b1;
                        pend_code_d = ERR_CSUM;
                    end else if (!rx_frame_end) begin
                        state_d     = S_DISCARD;
                        pend_err_d  = 1'b1;
                        pend_code_d = ERR_LEN;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = idle_next;
                case (cmd_q)
                    8'h01: begin
                        if (arg_ok) begin
                            num_d = arg_q;
                            ok_d  = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_CMD;
                        end
                    end
                    8'h02: begin
                        if (sample_busy) begin
                            err_d  = 1'b1;
                            code_d = ERR_BUSY;
                        end else begin
                            start_d = 1'b1;
                            ok_d    = 1'b1;
                        end
                    end
                    8'h03: begin
                        if (!arg_ok) begin
                            err_d  = 1'b1;
                            code_d = ERR_CMD;
                        end else if (sample_busy) begin
                            err_d  = 1'b1;
                            code_d = ERR_BUSY;
                        end else begin
                            num_d   = arg_q;
                            start_d = 1'b1;
                            ok_d    = 1'b1;
                        end
                    end
                    default: begin
                        err_d  = 1'b1;
                        code_d = ERR_CMD;
                    end
                endcase
            end
            S_DISCARD: begin
                if (rx_data_valid && rx_frame_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // An accepted byte in the expiry cycle wins over the timeout.
        if (state_q == S_HDR2 || state_q == S_CMD || state_q == S_ARG || state_q == S_CSUM) begin
            if (rx_data_valid) begin
                tmo_d = 24'd0;
            end else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                tmo_d       = 24'd0;
                state_d     = S_IDLE;
                pend_err_d  = 1'b1;
                pend_code_d = ERR_LEN;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'd0;
            arg_q       <= 32'd0;
            csum_q      <= 8'd0;
            cnt_q       <= 2'd0;
            pend_err_q  <= 1'b0;
            pend_code_q <= 2'd0;
            start_q     <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'd0;
            num_q       <= DEFAULT_SAMPLE_NUM;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            csum_q      <= csum_d;
            cnt_q       <= cnt_d;
            pend_err_q  <= pend_err_d;
            pend_code_q <= pend_code_d;
            start_q     <= start_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
            num_q       <= num_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= 24'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign start_sample   = start_q;
    assign cmd_ok         = ok_q;
    assign cmd_err        = err_q;
    assign err_code       = code_q;
    assign set_sample_num = num_q;

endmodule

// File: tb/tb_eth_cmd_decoder.sv
// Self-checking bench for eth_cmd_decoder: frame table plus hand-written corner sequences.
module tb_eth_cmd_decoder;

    localparam logic [23:0] TMO = 24'd200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_frame_end = 1'b0;
    logic        sample_busy = 1'b0;
    logic        start_sample;
    logic [31:0] set_sample_num;
    logic        cmd_ok;
    logic        cmd_err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    eth_cmd_decoder #(
        .DEFAULT_SAMPLE_NUM(32'd1024),
        .MAX_SAMPLE_NUM    (32'd67108864),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .rx_frame_end  (rx_frame_end),
        .sample_busy   (sample_busy),
        .start_sample  (start_sample),
        .set_sample_num(set_sample_num),
        .cmd_ok        (cmd_ok),
        .cmd_err       (cmd_err),
        .err_code      (err_code)
    );

    typedef struct {
        logic        ok;
        logic        start;
        logic        err;
        logic [1:0]  code;
        logic [31:0] num;
    } exp_t;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic        busy;
        logic        resp;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mke(input logic ok, input logic st, input logic er,
                                 input logic [1:0] code, input logic [31:0] num);
        exp_t e;
        e.ok = ok; e.start = st; e.err = er; e.code = code; e.num = num;
        return e;
    endfunction

    function automatic vec_t mk(input logic [63:0] b, input int n, input logic busy,
                                input logic resp, input exp_t e);
        vec_t v;
        v.bytes = b; v.n = n; v.busy = busy; v.resp = resp; v.e = e;
        return v;
    endfunction

    // Scoreboard: every response pulse pops one expected record.
    always @(negedge clk) begin
        if (reset_n && (cmd_ok || cmd_err || start_sample)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("cmd_ok", {31'd0, cmd_ok}, {31'd0, mon_e.ok});
                chk("start_sample", {31'd0, start_sample}, {31'd0, mon_e.start});
                chk("cmd_err", {31'd0, cmd_err}, {31'd0, mon_e.err});
                if (mon_e.err) chk("err_code", {30'd0, err_code}, {30'd0, mon_e.code});
                chk("set_sample_num", set_sample_num, mon_e.num);
            end
        end
    end

    // Called at a falling edge; the byte is sampled on the following rising edge.
    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_data_valid = 1'b1;
        rx_data       = b;
        rx_frame_end  = e;
        @(negedge clk);
    endtask

    task automatic end_frame(input logic resp);
        rx_data_valid = 1'b0;
        rx_frame_end  = 1'b0;
        chk("lat_early", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
        @(negedge clk);
        if (resp) begin
            chk("lat_pulse", {31'd0, cmd_ok | cmd_err}, 32'd1);
        end else begin
            chk("silent", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
            @(negedge clk);
            chk("silent2", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
        end
    endtask

    task automatic send_bytes(input logic [63:0] b, input int n, input logic end_last);
        logic [63:0] w;
        w = b;
        for (int k = 0; k < n; k++) begin
            send_byte(w[63-8*k -: 8], end_last && (k == n - 1));
        end
    endtask

    initial begin
        vecs[0]  = mk(64'h55A5010000100011, 8, 1'b0, 1'b1, mke(1, 0, 0, 2'd0, 32'h1000));
        vecs[1]  = mk(64'h55A5030000004043, 8, 1'b0, 1'b1, mke(1, 1, 0, 2'd0, 32'd64));
        vecs[2]  = mk(64'h55A5030000008083, 8, 1'b1, 1'b1, mke(0, 0, 1, 2'd3, 32'd64));
        vecs[3]  = mk(64'h55A5020000000000, 8, 1'b0, 1'b1, mke(0, 0, 1, 2'd0, 32'd64));
        vecs[4]  = mk(64'h55A5010000000001, 8, 1'b0, 1'b1, mke(0, 0, 1, 2'd2, 32'd64));
        vecs[5]  = mk(64'h55A5010400000106, 8, 1'b0, 1'b1, mke(0, 0, 1, 2'd2, 32'd64));
        vecs[6]  = mk(64'h55A57F0000000180, 8, 1'b0, 1'b1, mke(0, 0, 1, 2'd2, 32'd64));
        vecs[7]  = mk(64'h55A5010400000005, 8, 1'b0, 1'b1, mke(1, 0, 0, 2'd0, 32'h04000000));
        vecs[8]  = mk(64'h55A50100FFFFFFFE, 8, 1'b0, 1'b1, mke(1, 0, 0, 2'd0, 32'h00FFFFFF));
        vecs[9]  = mk(64'h1234000000000000, 2, 1'b0, 1'b0, mke(0, 0, 0, 2'd0, 32'h00FFFFFF));
        vecs[10] = mk(64'h55A5010000000102, 8, 1'b0, 1'b1, mke(1, 0, 0, 2'd0, 32'd1));
        vecs[11] = mk(64'h55A5020000000002, 8, 1'b1, 1'b1, mke(0, 0, 1, 2'd3, 32'd1));
        vecs[12] = mk(64'h55A5020000000002, 8, 1'b0, 1'b1, mke(1, 1, 0, 2'd0, 32'd1));
        vecs[13] = mk(64'h55A5010000000000, 5, 1'b0, 1'b1, mke(0, 0, 1, 2'd1, 32'd1));
        vecs[14] = mk(64'h5500334400000000, 4, 1'b0, 1'b0, mke(0, 0, 0, 2'd0, 32'd1));
        vecs[15] = mk(64'h55A5000000000000, 2, 1'b0, 1'b1, mke(0, 0, 1, 2'd1, 32'd1));
        vecs[16] = mk(64'h55A5030000004043, 8, 1'b0, 1'b1, mke(1, 1, 0, 2'd0, 32'd64));

        repeat (2) @(negedge clk);
        chk("rst_num", set_sample_num, 32'd1024);
        chk("rst_pulses", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
        chk("rst_code", {30'd0, err_code}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            sample_busy = vecs[i].busy;
            if (vecs[i].resp) sb.push_back(vecs[i].e);
            send_bytes(vecs[i].bytes, vecs[i].n, 1'b1);
            end_frame(vecs[i].resp);
        end
        sample_busy = 1'b0;

        // Good checksum but no frame end: length error, then trailing byte dropped.
        sb.push_back(mke(0, 0, 1, 2'd1, 32'd64));
        send_bytes(64'h55A5010000100011, 8, 1'b0);
        end_frame(1'b1);
        send_byte(8'h99, 1'b1);
        end_frame(1'b0);

        // Bad checksum without frame end: one checksum error, rest discarded.
        sb.push_back(mke(0, 0, 1, 2'd0, 32'd64));
        send_bytes(64'h55A5020000000000, 8, 1'b0);
        end_frame(1'b1);
        send_bytes(64'h5566770000000000, 3, 1'b1);
        end_frame(1'b0);

`ifdef CMD_TIMEOUT_EN
        begin
            int waited;
            logic found;
            waited = 0;
            found  = 1'b0;
            sb.push_back(mke(0, 0, 1, 2'd1, 32'd64));
            send_bytes(64'h55A5020000000000, 3, 1'b0);
            rx_data_valid = 1'b0;
            for (int i = 1; i <= int'(TMO) + 20 && !found; i++) begin
                @(negedge clk);
                if (cmd_err) begin
                    found  = 1'b1;
                    waited = i;
                end
            end
            chk("timeout_seen", {31'd0, found}, 32'd1);
            chk("timeout_lat", {31'd0, (waited >= int'(TMO)) && (waited <= int'(TMO) + 3)}, 32'd1);
            @(negedge clk);
        end
`else
        sb.push_back(mke(1, 1, 0, 2'd0, 32'd64));
        send_bytes(64'h55A5020000000000, 7, 1'b0);
        rx_data_valid = 1'b0;
        repeat (300) @(negedge clk);
        chk("no_timeout", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
        send_byte(8'h02, 1'b1);
        end_frame(1'b1);
`endif

        // Reset mid-frame drops the partial frame and restores defaults.
        send_bytes(64'h55A5010000000000, 4, 1'b0);
        reset_n = 1'b0;
        rx_data_valid = 1'b0;
        #1;
        chk("midrst_num", set_sample_num, 32'd1024);
        chk("midrst_pulses", {29'd0, cmd_ok, cmd_err, start_sample}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_bytes(64'h0010001100000000, 4, 1'b1);
        end_frame(1'b0);

        sb.push_back(mke(1, 0, 0, 2'd0, 32'h1000));
        send_bytes(64'h55A5010000100011, 8, 1'b1);
        end_frame(1'b1);
        @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
